// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by the receiver, transmitter and baud rate generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;
    localparam int unsigned LAST_TICK  = 15;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is a parameter so idle-high and idle-low lines can share it.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver. Define UART_RX_PARITY_EN to add an
// even-parity bit after the data bits and the o_parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_err,
`endif
    output logic               o_frame_err
);

    localparam int NW = $clog2(NB_DATA);

    uart_state_t        state_q, state_d;
    logic [3:0]         s_cnt_q, s_cnt_d;
    logic [NW-1:0]      n_cnt_q, n_cnt_d;
    logic [0:0]         stop_q, stop_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               err_q, err_d;
    logic [NB_DATA-1:0] data_d;
    logic               done_d, ferr_d;
    logic               rx_s, rx_prev;
`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d;
    logic               perr_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            stop_q      <= '0;
            shreg_q     <= '0;
            err_q       <= 1'b0;
            rx_prev     <= 1'b1;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            stop_q      <= stop_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
            rx_prev     <= rx_s;
            o_data      <= data_d;
            o_rx_done   <= done_d;
            o_frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            o_parity_err <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        err_d   = err_q;
        data_d  = o_data;
        done_d  = 1'b0;
        ferr_d  = o_frame_err;
`ifdef UART_RX_PARITY_EN
        par_d  = par_q;
        perr_d = o_parity_err;
`endif
        case (state_q)
            // Falling edge only, so a held-low break cannot re-trigger.
            IDLE: if (rx_prev && !rx_s) begin
                state_d = START;
                s_cnt_d = '0;
                err_d   = 1'b0;
            end
            START: if (i_tick) begin
                if (s_cnt_q == 4'(MID_TICK)) begin
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    s_cnt_d = s_cnt_q + 4'd1;
                end
            end
            DATA: if (i_tick) begin
                if (s_cnt_q == 4'(LAST_TICK)) begin
                    s_cnt_d = '0;
                    shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
                    if (n_cnt_q == NW'(NB_DATA - 1)) begin
                        stop_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_cnt_d = n_cnt_q + 1'b1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (i_tick) begin
                if (s_cnt_q == 4'(LAST_TICK)) begin
                    s_cnt_d = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    s_cnt_d = s_cnt_q + 4'd1;
                end
            end
`endif
            STOP: if (i_tick) begin
                if (s_cnt_q == 4'(LAST_TICK)) begin
                    s_cnt_d = '0;
                    err_d   = err_q | ~rx_s;
                    if (stop_q == 1'(NB_STOP - 1)) begin
                        done_d  = 1'b1;
                        data_d  = shreg_q;
                        ferr_d  = err_d;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shreg_q, par_q};
`endif
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8N1, tick every 4 clocks).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int tick_total = 0;
    int start_base = 0;
    int done_cnt = 0;
    int last_lat = 0;
    int phase = 0;
    int prev_done;

    uart_rx #(.NB_DATA(8), .NB_STOP(1)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    // Tick strobe every 4 clocks, changed 2 ns after the edge.
    always @(posedge clk) begin
        if (i_tick) tick_total++;
        #2;
        phase = (phase + 1) % 4;
        i_tick = (phase == 0);
    end

    always @(negedge clk) begin
        if (o_rx_done === 1'b1) begin
            done_cnt++;
            last_lat = tick_total - start_base;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start edge is detected on the 3rd clock after driving low; ticks count after that.
    task automatic send_frame(input logic [7:0] d, input logic par);
        i_rx = 1'b0;
        hold(3);
        start_base = tick_total;
        hold(61);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            hold(64);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par;
        hold(64);
`else
        if (par) i_rx = 1'b1;
`endif
        i_rx = 1'b1;
        hold(64);
    endtask

    initial begin
        hold(5);
        @(negedge clk);
        check("rst_data", o_data, 8'h00);
        check("rst_done", o_rx_done, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        hold(1);
        i_rst = 1'b0;
        hold(20);

        // 0x55 on-grid
        prev_done = done_cnt;
        send_frame(8'h55, 1'b0);
        check("f55_cnt", done_cnt, prev_done + 1);
        check("f55_data", o_data, 8'h55);
        check("f55_ferr", o_frame_err, 1'b0);
        check("f55_lat", last_lat, 152);

        // back-to-back frames
        prev_done = done_cnt;
        send_frame(8'hA3, 1'b0);
        check("fa3_cnt", done_cnt, prev_done + 1);
        check("fa3_data", o_data, 8'hA3);
        send_frame(8'h0F, 1'b0);
        check("f0f_cnt", done_cnt, prev_done + 2);
        check("f0f_data", o_data, 8'h0F);
        check("f0f_ferr", o_frame_err, 1'b0);
        check("f0f_lat", last_lat, 152);
        hold(50);

        // start glitch: 4 ticks low
        prev_done = done_cnt;
        i_rx = 1'b0;
        hold(16);
        i_rx = 1'b1;
        hold(200);
        check("glitch_cnt", done_cnt, prev_done);
        check("glitch_data", o_data, 8'h0F);
        send_frame(8'h96, 1'b0);
        check("f96_cnt", done_cnt, prev_done + 1);
        check("f96_data", o_data, 8'h96);
        hold(50);

        // reset during data bit 3 of 0xC6 (bits LSB first: 0,1,1,0,...)
        prev_done = done_cnt;
        i_rx = 1'b0; hold(64);
        i_rx = 1'b0; hold(64);
        i_rx = 1'b1; hold(64);
        i_rx = 1'b1; hold(64);
        i_rx = 1'b0; hold(32);
        i_rst = 1'b1;
        i_rx = 1'b1;
        hold(4);
        @(negedge clk);
        check("mrst_data", o_data, 8'h00);
        check("mrst_done", o_rx_done, 1'b0);
        check("mrst_ferr", o_frame_err, 1'b0);
        hold(1);
        i_rst = 1'b0;
        hold(400);
        check("mrst_cnt", done_cnt, prev_done);
        send_frame(8'h3C, 1'b0);
        check("f3c_cnt", done_cnt, prev_done + 1);
        check("f3c_data", o_data, 8'h3C);
        check("f3c_ferr", o_frame_err, 1'b0);
        hold(50);

        // break: 20 bit times low
        prev_done = done_cnt;
        i_rx = 1'b0;
        hold(3);
        start_base = tick_total;
        hold(20 * 64 - 3);
        check("brk_cnt", done_cnt, prev_done + 1);
        check("brk_data", o_data, 8'h00);
        check("brk_ferr", o_frame_err, 1'b1);
        check("brk_lat", last_lat, 152);
        i_rx = 1'b1;
        hold(200);
        check("brk_nomore", done_cnt, prev_done + 1);
        send_frame(8'hE1, 1'b0);
        check("fe1_data", o_data, 8'hE1);
        check("fe1_ferr", o_frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        hold(50);
        send_frame(8'h07, 1'b0);
        check("par0_perr", o_parity_err, 1'b1);
        hold(50);
        send_frame(8'h07, 1'b1);
        check("par1_perr", o_parity_err, 1'b0);
        check("par1_data", o_data, 8'h07);
`endif

        hold(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
